// File: rtl/tlb_unit_if.sv
// rtl/tlb_unit_if.sv - search, read, write and replacement signals of the joint TLB
interface tlb_unit_if;
  // search port 0 (instruction fetch)
  logic [18:0] s0_vpn2;
  logic        s0_odd_page;
  logic [7:0]  s0_asid;
  logic        s0_found;
  logic [3:0]  s0_index;
  logic [19:0] s0_pfn;
  logic [2:0]  s0_c;
  logic        s0_d;
  logic        s0_v;

  // search port 1 (load/store, TLBP)
  logic [18:0] s1_vpn2;
  logic        s1_odd_page;
  logic [7:0]  s1_asid;
  logic        s1_found;
  logic [3:0]  s1_index;
  logic [19:0] s1_pfn;
  logic [2:0]  s1_c;
  logic        s1_d;
  logic        s1_v;

  // indexed write port (TLBWI/TLBWR)
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0;
  logic [2:0]  w_c0;
  logic        w_d0;
  logic        w_v0;
  logic [19:0] w_pfn1;
  logic [2:0]  w_c1;
  logic        w_d1;
  logic        w_v1;

  // indexed read port (TLBR)
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0;
  logic [2:0]  r_c0;
  logic        r_d0;
  logic        r_v0;
  logic [19:0] r_pfn1;
  logic [2:0]  r_c1;
  logic        r_d1;
  logic        r_v1;

  logic [3:0]  random_index;

  modport master (
    output s0_vpn2, s0_odd_page, s0_asid,
    input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_vpn2, s1_odd_page, s1_asid,
    input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output we, w_index, w_vpn2, w_asid, w_g,
    output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    output r_index,
    input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    input  random_index
  );

  modport slave (
    input  s0_vpn2, s0_odd_page, s0_asid,
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input  s1_vpn2, s1_odd_page, s1_asid,
    output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input  we, w_index, w_vpn2, w_asid, w_g,
    input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    input  r_index,
    output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    output random_index
  );
endinterface

// File: rtl/tlb_unit.sv
// rtl/tlb_unit.sv - 16-entry fully associative joint TLB, two search ports, TLBR/TLBW ports
module tlb_unit (
  input  logic       clk,
  input  logic       reset,
  tlb_unit_if.slave  tlb
);
  localparam int TLBNUM = 16;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } hit_t;

  entry_t     ents [TLBNUM];
  logic [3:0] random_q;
  hit_t       hit0;
  hit_t       hit1;
  entry_t     rd;

  // Scanning from the top down lets the lowest matching index overwrite the rest,
  // so simultaneous hits resolve deterministically to the smallest index.
  function automatic hit_t lookup(input entry_t tbl [TLBNUM], input logic [18:0] vpn2,
                                  input logic odd, input logic [7:0] asid);
    hit_t h;
    h = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (tbl[i].vpn2 == vpn2 && (tbl[i].g || tbl[i].asid == asid)) begin
        h.found = 1'b1;
        h.index = 4'(i);
        if (odd) begin
          h.pfn = tbl[i].pfn1;
          h.c   = tbl[i].c1;
          h.d   = tbl[i].d1;
          h.v   = tbl[i].v1;
        end else begin
          h.pfn = tbl[i].pfn0;
          h.c   = tbl[i].c0;
          h.d   = tbl[i].d0;
          h.v   = tbl[i].v0;
        end
      end
    end
    return h;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) ents[i] <= '0;
      random_q <= 4'hF;
    end else begin
      random_q <= random_q - 4'd1;
      if (tlb.we) begin
        ents[tlb.w_index] <= '{vpn2: tlb.w_vpn2, asid: tlb.w_asid, g: tlb.w_g,
                               pfn0: tlb.w_pfn0, c0: tlb.w_c0, d0: tlb.w_d0, v0: tlb.w_v0,
                               pfn1: tlb.w_pfn1, c1: tlb.w_c1, d1: tlb.w_d1, v1: tlb.w_v1};
      end
    end
  end

  // Lookups see the array as it stands; a write lands only after the edge.
  always_comb begin
    hit0 = lookup(ents, tlb.s0_vpn2, tlb.s0_odd_page, tlb.s0_asid);
    hit1 = lookup(ents, tlb.s1_vpn2, tlb.s1_odd_page, tlb.s1_asid);
    rd   = ents[tlb.r_index];
  end

  assign tlb.s0_found = hit0.found;
  assign tlb.s0_index = hit0.index;
  assign tlb.s0_pfn   = hit0.pfn;
  assign tlb.s0_c     = hit0.c;
  assign tlb.s0_d     = hit0.d;
  assign tlb.s0_v     = hit0.v;

  assign tlb.s1_found = hit1.found;
  assign tlb.s1_index = hit1.index;
  assign tlb.s1_pfn   = hit1.pfn;
  assign tlb.s1_c     = hit1.c;
  assign tlb.s1_d     = hit1.d;
  assign tlb.s1_v     = hit1.v;

  assign tlb.r_vpn2 = rd.vpn2;
  assign tlb.r_asid = rd.asid;
  assign tlb.r_g    = rd.g;
  assign tlb.r_pfn0 = rd.pfn0;
  assign tlb.r_c0   = rd.c0;
  assign tlb.r_d0   = rd.d0;
  assign tlb.r_v0   = rd.v0;
  assign tlb.r_pfn1 = rd.pfn1;
  assign tlb.r_c1   = rd.c1;
  assign tlb.r_d1   = rd.d1;
  assign tlb.r_v1   = rd.v1;

  assign tlb.random_index = random_q;
endmodule

// File: tb/tb_tlb_unit.sv
// tb/tb_tlb_unit.sv - table-driven, scoreboarded bench for tlb_unit
module tb_tlb_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_unit_if tlb ();
  tlb_unit dut (.clk(clk), .reset(reset), .tlb(tlb));

  typedef struct {
    int          phase;
    bit          pair;
    bit          port;
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
    logic [29:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   failed = 0;

  function automatic logic [29:0] res(bit f, int idx, int pfn, int c, int d, int v);
    return {f, 4'(idx), 20'(pfn), 3'(c), 1'(d), 1'(v)};
  endfunction

  function automatic void add(int ph, bit pr, bit port, int vpn2, bit odd, int asid,
                              logic [29:0] e, string nm);
    vec_t v;
    v.phase = ph; v.pair = pr; v.port = port; v.vpn2 = 19'(vpn2);
    v.odd = odd; v.asid = 8'(asid); v.exp = e; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic drive(vec_t v);
    if (v.port) begin
      tlb.s1_vpn2 = v.vpn2; tlb.s1_odd_page = v.odd; tlb.s1_asid = v.asid;
    end else begin
      tlb.s0_vpn2 = v.vpn2; tlb.s0_odd_page = v.odd; tlb.s0_asid = v.asid;
    end
    sb.push_back(v);
  endtask

  task automatic check_sb();
    vec_t v;
    logic [29:0] got;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      got = v.port ? {tlb.s1_found, tlb.s1_index, tlb.s1_pfn, tlb.s1_c, tlb.s1_d, tlb.s1_v}
                   : {tlb.s0_found, tlb.s0_index, tlb.s0_pfn, tlb.s0_c, tlb.s0_d, tlb.s0_v};
      tests++;
      if (got !== v.exp) begin
        failed++;
        $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
      end
    end
  endtask

  task automatic check_val(string nm, logic [127:0] got, logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_read(string nm, logic [77:0] exp);
    check_val(nm, {tlb.r_vpn2, tlb.r_asid, tlb.r_g, tlb.r_pfn0, tlb.r_c0, tlb.r_d0, tlb.r_v0,
                   tlb.r_pfn1, tlb.r_c1, tlb.r_d1, tlb.r_v1}, 128'(exp));
  endtask

  task automatic run_phase(int ph);
    bit held = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        if (!held) @(negedge clk);
        drive(vecs[i]);
        held = vecs[i].pair;
        if (!held) begin
          #2;
          check_sb();
        end
      end
    end
  endtask

  task automatic write_start(int idx, int vpn2, int asid, bit g, int pfn0, int c0, bit d0,
                             bit v0, int pfn1, int c1, bit d1, bit v1);
    @(negedge clk);
    tlb.we = 1'b1; tlb.w_index = 4'(idx); tlb.w_vpn2 = 19'(vpn2); tlb.w_asid = 8'(asid);
    tlb.w_g = g; tlb.w_pfn0 = 20'(pfn0); tlb.w_c0 = 3'(c0); tlb.w_d0 = d0; tlb.w_v0 = v0;
    tlb.w_pfn1 = 20'(pfn1); tlb.w_c1 = 3'(c1); tlb.w_d1 = d1; tlb.w_v1 = v1;
  endtask

  task automatic counter_run(string nm);
    check_val({nm, "_first"}, 128'(tlb.random_index), 128'(15));
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      #2;
      check_val(nm, 128'(tlb.random_index), 128'((15 - n) & 15));
    end
  endtask

  initial begin
    add(0, 0, 0, 0, 0, 0, res(1, 0, 0, 0, 0, 0), "reset_hit_idx0");
    add(0, 0, 1, 0, 0, 8'h33, res(0, 0, 0, 0, 0, 0), "reset_asid_miss");
    add(0, 0, 0, 1, 1, 0, res(0, 0, 0, 0, 0, 0), "reset_vpn_miss");
    add(1, 0, 1, 19'h12345, 0, 8'h07, res(1, 3, 20'hABCDE, 3, 1, 1), "s1_even");
    add(1, 0, 1, 19'h12345, 1, 8'h07, res(1, 3, 20'h11111, 2, 0, 1), "s1_odd");
    add(1, 0, 0, 19'h12345, 0, 8'h07, res(1, 3, 20'hABCDE, 3, 1, 1), "s0_even");
    add(1, 0, 1, 19'h12345, 0, 8'h08, res(0, 0, 0, 0, 0, 0), "asid_miss");
    add(1, 0, 0, 0, 0, 0, res(1, 0, 0, 0, 0, 0), "zero_entry_hit");
    add(2, 0, 0, 19'h12345, 0, 8'h08, res(1, 3, 20'hABCDE, 3, 1, 1), "global_s0");
    add(2, 0, 1, 19'h12345, 1, 8'hFF, res(1, 3, 20'h11111, 2, 0, 1), "global_s1");
    add(3, 0, 0, 19'h55555, 0, 8'h21, res(1, 4, 4, 0, 0, 1), "multi_s0");
    add(3, 0, 1, 19'h55555, 0, 8'h21, res(1, 4, 4, 0, 0, 1), "multi_s1");
    add(4, 1, 0, 19'h55555, 0, 8'h21, res(1, 4, 4, 0, 0, 1), "dual_s0_hit");
    add(4, 0, 1, 19'h7FFFF, 0, 8'h21, res(0, 0, 0, 0, 0, 0), "dual_s1_miss");
    add(5, 0, 1, 19'h12345, 0, 8'h08, res(0, 0, 0, 0, 0, 0), "post_reset_e3");
    add(5, 0, 0, 19'h55555, 0, 8'h21, res(0, 0, 0, 0, 0, 0), "post_reset_e4");

    reset = 1'b1;
    tlb.s0_vpn2 = '0; tlb.s0_odd_page = 1'b0; tlb.s0_asid = '0;
    tlb.s1_vpn2 = '0; tlb.s1_odd_page = 1'b0; tlb.s1_asid = '0;
    tlb.we = 1'b0; tlb.w_index = '0; tlb.w_vpn2 = '0; tlb.w_asid = '0; tlb.w_g = 1'b0;
    tlb.w_pfn0 = '0; tlb.w_c0 = '0; tlb.w_d0 = 1'b0; tlb.w_v0 = 1'b0;
    tlb.w_pfn1 = '0; tlb.w_c1 = '0; tlb.w_d1 = 1'b0; tlb.w_v1 = 1'b0;
    tlb.r_index = 4'd5;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    counter_run("random");
    run_phase(0);
    check_read("reset_read5", '0);

    write_start(3, 19'h12345, 8'h07, 0, 20'hABCDE, 3, 1, 1, 20'h11111, 2, 0, 1);
    tlb.r_index = 4'd3;
    begin
      vec_t v;
      v.phase = 9; v.pair = 0; v.port = 1; v.vpn2 = 19'h12345; v.odd = 0; v.asid = 8'h07;
      v.exp = res(0, 0, 0, 0, 0, 0); v.name = "same_cycle_old";
      drive(v);
    end
    #2;
    check_sb();
    check_read("same_cycle_read_old", '0);
    @(negedge clk);
    tlb.we = 1'b0;
    #2;
    check_read("read_e3", {19'h12345, 8'h07, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1,
                           20'h11111, 3'd2, 1'b0, 1'b1});
    run_phase(1);

    write_start(3, 19'h12345, 8'h07, 1, 20'hABCDE, 3, 1, 1, 20'h11111, 2, 0, 1);
    @(negedge clk);
    tlb.we = 1'b0;
    run_phase(2);

    write_start(9, 19'h55555, 8'h21, 0, 9, 0, 0, 1, 0, 0, 0, 0);
    write_start(4, 19'h55555, 8'h21, 0, 4, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    tlb.we = 1'b0;
    run_phase(3);
    run_phase(4);

    write_start(2, 19'h2AAAA, 8'h5A, 1, 20'hFFFFF, 7, 1, 1, 20'hEEEEE, 5, 1, 1);
    reset = 1'b1;
    tlb.r_index = 4'd2;
    @(negedge clk);
    reset = 1'b0;
    tlb.we = 1'b0;
    #2;
    check_read("reset_beats_we", '0);
    counter_run("random_after_reset");
    run_phase(5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
